// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - shared multiply/divide op encodings and default latencies
package md_unit_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;
    localparam int MD_CNT_W_DEF       = 4;

    // Ops that occupy the unit for a busy period
    function automatic logic md_is_long(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_signed(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_compute.sv
// rtl/md_compute.sv - combinational signed/unsigned multiply and divide returning {hi,lo}
module md_compute (
    input  logic        is_signed,
    input  logic        is_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic        a_neg;
    logic        b_neg;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        a_neg = is_signed & a[31];
        b_neg = is_signed & b[31];

        // Low 64 bits of a 64x64 product of extended operands give the exact result
        a_ext = {{32{a_neg}}, a};
        b_ext = {{32{b_neg}}, b};
        prod  = a_ext * b_ext;

        // Divide on magnitudes; 0x80000000 / -1 wraps back to 0x80000000
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
        if (b_mag == 32'd0) begin
            q_mag = 32'd0;
            r_mag = 32'd0;
        end else begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem  = a_neg ? -r_mag : r_mag;

        result = is_div ? {rem, quot} : prod;
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - iterative multiply/divide unit owning HI/LO with busy/stall export
import md_unit_pkg::*;

module md_unit #(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int CNT_W       = MD_CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] x_result
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        pending_hi;
    logic [31:0]        pending_lo;
    logic [63:0]        comp_result;

    md_compute u_compute (
        .is_signed (md_is_signed(md_op)),
        .is_div    (md_is_div(md_op)),
        .a         (rs_val),
        .b         (rt_val),
        .result    (comp_result)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            hi         <= 32'd0;
            lo         <= 32'd0;
            pending_hi <= 32'd0;
            pending_lo <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                {pending_hi, pending_lo} <= comp_result;
                                cnt   <= MULT_LOAD;
                                busy  <= 1'b1;
                                state <= ST_BUSY;
                            end
                            MD_DIV, MD_DIVU: begin
                                // Divide by zero still burns the full latency but commits the old HI/LO
                                if (rt_val == 32'd0) begin
                                    pending_hi <= hi;
                                    pending_lo <= lo;
                                end else begin
                                    {pending_hi, pending_lo} <= comp_result;
                                end
                                cnt   <= DIV_LOAD;
                                busy  <= 1'b1;
                                state <= ST_BUSY;
                            end
                            MD_MTHI: hi <= rs_val;
                            MD_MTLO: lo <= rs_val;
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        hi    <= pending_hi;
                        lo    <= pending_lo;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign md_stall = busy | (start & md_is_long(md_op));

    always_comb begin
        x_result = 32'd0;
        if (md_op == MD_MFHI) begin
            x_result = hi;
        end else if (md_op == MD_MFLO) begin
            x_result = lo;
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit against a behavioural HI/LO model
import md_unit_pkg::*;

module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] x_result;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo),
        .x_result (x_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural model: HI/LO plus the number of busy cycles still owed
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    int          m_rem = 0;

    always @(posedge clk) begin
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        if (reset) begin
            m_hi = 0; m_lo = 0; m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            sa = longint'($signed(rs_val)); sb = longint'($signed(rt_val));
            ua = {32'd0, rs_val};           ub = {32'd0, rt_val};
            case (md_op)
                MD_MULT:  begin p = 64'(sa * sb); {p_hi, p_lo} = p; m_rem = 5; end
                MD_MULTU: begin p = ua * ub;      {p_hi, p_lo} = p; m_rem = 5; end
                MD_DIV, MD_DIVU: begin
                    m_rem = 10;
                    if (rt_val == 0) begin
                        p_hi = m_hi; p_lo = m_lo;
                    end else if (md_op == MD_DIV) begin
                        p_lo = 32'(sa / sb); p_hi = 32'(sa % sb);
                    end else begin
                        p_lo = 32'(ua / ub); p_hi = 32'(ua % ub);
                    end
                end
                MD_MTHI: m_hi = rs_val;
                MD_MTLO: m_lo = rs_val;
                default: ;
            endcase
        end
    end

    initial begin
        logic [31:0] exp_x;
        logic        exp_stall;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_x = (md_op == MD_MFHI) ? m_hi : (md_op == MD_MFLO) ? m_lo : 32'd0;
                exp_stall = (m_rem > 0) || (start && md_op >= 4'd1 && md_op <= 4'd4);
                check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
                check("md_stall", {31'd0, md_stall}, {31'd0, exp_stall});
                check("hi", hi, m_hi);
                check("lo", lo, m_lo);
                check("x_result", x_result, exp_x);
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(posedge clk); #2;
        start = 1'b0; md_op = MD_NONE;
    endtask

    task automatic wait_done(input string name, input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) n++;
            else break;
        end
        check(name, n, exp_n);
        @(posedge clk); #2;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_NONE; rs_val = 0; rt_val = 0;
        cycles(2);
        reset = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // MULT -3 * 5
        start = 1'b1; md_op = MD_MULT; rs_val = 32'hFFFF_FFFD; rt_val = 32'd5;
        #1 check("mult_stall_start", {31'd0, md_stall}, 32'd1);
        @(posedge clk); #2; start = 1'b0; md_op = MD_NONE;
        wait_done("mult_busy_len", 5);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFF1);

        // MULTU 0xFFFFFFFF * 2 then MFHI
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done("multu_busy_len", 5);
        check("multu_hi", hi, 32'h0000_0001);
        check("multu_lo", lo, 32'hFFFF_FFFE);
        start = 1'b1; md_op = MD_MFHI;
        #1 check("mfhi_after_multu", x_result, 32'd1);
        @(posedge clk); #2; start = 1'b0; md_op = MD_NONE;

        // Signed MULT of two most-negative values
        issue(MD_MULT, 32'h8000_0000, 32'h8000_0000);
        wait_done("mult_min_busy", 5);
        check("mult_min_hi", hi, 32'h4000_0000);
        check("mult_min_lo", lo, 32'h0000_0000);

        // DIV -7 / 2
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_busy_len", 10);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU 7 / 0 leaves HI/LO intact
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        issue(MD_MTLO, 32'h1234_5678, 32'd0);
        issue(MD_DIVU, 32'd7, 32'd0);
        wait_done("divz_busy_len", 10);
        check("divz_hi", hi, 32'h1234_5678);
        check("divz_lo", lo, 32'h1234_5678);

        // DIV overflow case
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("divovf_busy_len", 10);
        check("divovf_lo", lo, 32'h8000_0000);
        check("divovf_hi", hi, 32'h0000_0000);

        // MULT 3*4 with MTLO attempted on busy cycle 2
        issue(MD_MULT, 32'd3, 32'd4);
        cycles(1);
        issue(MD_MTLO, 32'h0000_AAAA, 32'd0);
        wait_done("mult_ign_busy", 3);
        check("mult_ign_lo", lo, 32'h0000_000C);
        check("mult_ign_hi", hi, 32'h0000_0000);

        // DIV aborted by reset on busy cycle 4
        issue(MD_MTHI, 32'h1111_1111, 32'd0);
        issue(MD_DIV, 32'd100, 32'd7);
        cycles(3);
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        cycles(12);
        check("abort_nocommit_hi", hi, 32'd0);
        check("abort_nocommit_lo", lo, 32'd0);

        // MTHI then MFHI
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        start = 1'b1; md_op = MD_MFHI;
        #1 check("mfhi_x", x_result, 32'hDEAD_BEEF);
        check("mthi_no_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2; start = 1'b0; md_op = MD_MFLO;
        #1 check("mflo_x", x_result, 32'd0);
        md_op = MD_NONE;

        // Undefined op codes do nothing
        for (int op = 9; op < 16; op++) begin
            start = 1'b1; md_op = 4'(op); rs_val = 32'hFFFF_0000; rt_val = 32'd3;
            @(posedge clk); #2;
        end
        start = 1'b0; md_op = MD_NONE;
        check("undef_hi", hi, 32'hDEAD_BEEF);
        check("undef_lo", lo, 32'd0);
        cycles(2);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
